alu_issue_stage: RTL

- Sequential front-end that sits directly upstream of the combinational 4-bit ALU.
- Queues operation requests, drives the ALU operand/control inputs from registered state, and captures the ALU outputs into a result register with a valid/ready handshake.
- Holds carry and borrow flags so multi-word ADD/SUB chains can be issued as back-to-back requests.

---
 rtl/alu_issue_stage_pkg.sv | 31 +++
 rtl/alu_issue_stage_if.sv | 33 +++
 rtl/alu_cmd_fifo.sv | 43 ++++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared opcodes and command-entry layout for the ALU issue stage.
package alu_issue_stage_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_GT   = 3'b011;
  localparam logic [2:0] OP_LT   = 3'b100;
  localparam logic [2:0] OP_EQ   = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  localparam int CMD_W       = 14;
  localparam int CMD_OP_LSB  = 11;
  localparam int CMD_A_LSB   = 7;
  localparam int CMD_B_LSB   = 3;
  localparam int CMD_CIN_BIT = 2;
  localparam int CMD_BIN_BIT = 1;
  localparam int CMD_CHN_BIT = 0;

  // Field order must match the *_LSB offsets above.
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       bin;
    logic       chain;
  } cmd_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Request, ALU-drive and response signals of the issue stage.
interface alu_issue_stage_if;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a, req_b;
  logic       req_cin, req_bin, req_chain;
  logic       flags_clr;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_control;
  logic       alu_c_in, alu_b_in;
  logic [3:0] alu_c;
  logic       alu_c_out, alu_b_out;
  logic [1:0] alu_compare;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_c;
  logic       rsp_c_out, rsp_b_out;
  logic [1:0] rsp_compare;
  logic [2:0] rsp_op;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, req_bin, req_chain, flags_clr,
           alu_c, alu_c_out, alu_b_out, alu_compare, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control, alu_c_in, alu_b_in,
           rsp_valid, rsp_c, rsp_c_out, rsp_b_out, rsp_compare, rsp_op
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, req_bin, req_chain, flags_clr,
           alu_c, alu_c_out, alu_b_out, alu_compare, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control, alu_c_in, alu_b_in,
           rsp_valid, rsp_c, rsp_c_out, rsp_b_out, rsp_compare, rsp_op
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH x W synchronous FIFO, async active-high reset, head visible combinationally.
module alu_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 4-bit combinational ALU: command FIFO, chained carry/borrow flags,
// registered result. Optional perf counters behind ALU_ISSUE_PERF_CNT_EN.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   bus
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   issue_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);
  cmd_t       push_cmd, head;
  logic       full, empty, push, issue;
  logic       rsp_valid_q, rsp_c_out_q, rsp_b_out_q;
  logic [3:0] rsp_c_q;
  logic [1:0] rsp_compare_q;
  logic [2:0] rsp_op_q;
  logic       carry_q, borrow_q;

  assign push_cmd = '{op: bus.req_op, a: bus.req_a, b: bus.req_b,
                      cin: bus.req_cin, bin: bus.req_bin, chain: bus.req_chain};
  assign bus.req_ready = !full;
  assign push  = bus.req_valid && !full;
  assign issue = !empty && (!rsp_valid_q || bus.rsp_ready);

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (push_cmd),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = '0;
    bus.alu_c_in    = 1'b0;
    bus.alu_b_in    = 1'b0;
    if (!empty) begin
      bus.alu_a       = head.a;
      bus.alu_b       = head.b;
      bus.alu_control = head.op;
      bus.alu_c_in    = (head.chain && head.op == OP_ADD) ? carry_q  : head.cin;
      bus.alu_b_in    = (head.chain && head.op == OP_SUB) ? borrow_q : head.bin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_c_q       <= '0;
      rsp_c_out_q   <= 1'b0;
      rsp_b_out_q   <= 1'b0;
      rsp_compare_q <= '0;
      rsp_op_q      <= '0;
    end else if (issue) begin
      rsp_valid_q   <= 1'b1;
      rsp_c_q       <= bus.alu_c;
      rsp_c_out_q   <= bus.alu_c_out;
      rsp_b_out_q   <= bus.alu_b_out;
      rsp_compare_q <= bus.alu_compare;
      rsp_op_q      <= head.op;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  // Clear wins over a same-edge update from an issuing ADD/SUB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (bus.flags_clr) begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (issue) begin
      if (head.op == OP_ADD) carry_q  <= bus.alu_c_out;
      if (head.op == OP_SUB) borrow_q <= bus.alu_b_out;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_c       = rsp_c_q;
  assign bus.rsp_c_out   = rsp_c_out_q;
  assign bus.rsp_b_out   = rsp_b_out_q;
  assign bus.rsp_compare = rsp_compare_q;
  assign bus.rsp_op      = rsp_op_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue && issue_cnt_q != '1) issue_cnt_q <= issue_cnt_q + 1'b1;
      if (!empty && rsp_valid_q && !bus.rsp_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule
